// File: rtl/loader_pkg.sv
// Shared types, command bytes and ASCII-hex helpers for the UART hex program loader.
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ECHO  = 2'd1,
    S_CK_HI = 2'd2,
    S_CK_LO = 2'd3
  } state_t;

  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_CKSUM = 8'h58;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;

  // Returns {valid, nibble}; valid is 0 for any byte that is not an ASCII hex digit.
  function automatic logic [4:0] hex2nib(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
    else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
    else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/hex_word_assembler.sv
// Shifts ASCII-hex nibbles MSB-first into a word; pulses done the cycle after the last nibble.
module hex_word_assembler
  import loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [3:0]        nib,
  input  logic              clear,
  output logic [DATA_W-1:0] word,
  output logic              done,
  output logic              pending
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      word <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (shift_en) begin
        word <= (word << 4) | DATA_W'(nib);
        if (cnt == CNT_W'(NIB - 1)) begin
          cnt  <= '0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign pending = (cnt != '0);

endmodule

// File: rtl/uart_hex_prog_loader.sv
// ASCII-hex UART stream to program-memory write loader with byte echo.
// Optional checksum reporting on 'X' is enabled by defining LOADER_CKSUM_EN.
module uart_hex_prog_loader
  import loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WRAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              full,
  output logic              overflow,
  output logic              bad_char
);

`ifdef LOADER_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
`else
  localparam bit CKSUM_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   WL_MAX = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nx;
  logic [7:0]          echo_byte;
  logic [ADDR_W-1:0]   ptr;
  logic [4:0]          dec;
  logic                accept, is_hex, is_reset, is_eol, is_cksum, is_bad;
  logic                word_done, word_pending;
  logic [DATA_W-1:0]   word;
  logic [7:0]          cksum;

  assign accept   = rx_valid && rx_ready;
  assign dec      = hex2nib(rx_data);
  assign is_hex   = dec[4];
  assign is_reset = (rx_data == CMD_RESET);
  assign is_eol   = (rx_data == CR) || (rx_data == LF);
  assign is_cksum = CKSUM_EN && (rx_data == CMD_CKSUM);
  // CR/LF is only an error when it truncates a partially assembled word.
  assign is_bad   = (!is_hex && !is_reset && !is_eol && !is_cksum) || (is_eol && word_pending);

  hex_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept && is_hex),
    .nib      (dec[3:0]),
    .clear    (accept && (is_reset || is_eol)),
    .word     (word),
    .done     (word_done),
    .pending  (word_pending)
  );

  assign mem_we    = word_done && !full;
  assign mem_addr  = ptr;
  assign mem_wdata = word;

  always_ff @(posedge clk) begin
    if (accept) echo_byte <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state)
      S_IDLE: begin
        rx_ready = load_en && rst_n;
        if (rx_valid && load_en) state_nx = S_ECHO;
      end
      S_ECHO: begin
        tx_valid = 1'b1;
        tx_data  = echo_byte;
        if (tx_ready) state_nx = (CKSUM_EN && echo_byte == CMD_CKSUM) ? S_CK_HI : S_IDLE;
      end
      S_CK_HI: begin
        tx_valid = 1'b1;
        tx_data  = nib2hex(cksum[7:4]);
        if (tx_ready) state_nx = S_CK_LO;
      end
      S_CK_LO: begin
        tx_valid = 1'b1;
        tx_data  = nib2hex(cksum[3:0]);
        if (tx_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Accept and word_done never coincide: the write cycle is always spent in S_ECHO.
  always_ff @(posedge clk) begin
    if (!rst_n || (accept && is_reset)) begin
      ptr          <= '0;
      words_loaded <= '0;
      full         <= 1'b0;
      overflow     <= 1'b0;
      bad_char     <= 1'b0;
    end else begin
      if (accept && is_bad) bad_char <= 1'b1;
      if (word_done) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          if (ptr == LAST) begin
            if (WRAP != 0) ptr <= '0;
            else           full <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
          if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
        end
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  localparam int NBYTES = (DATA_W + 7) / 8;

  function automatic logic [7:0] xor_bytes(input logic [DATA_W-1:0] w);
    logic [NBYTES*8-1:0] p;
    logic [7:0]          r;
    p = (NBYTES * 8)'(w);
    r = 8'h00;
    for (int i = 0; i < NBYTES; i++) r = r ^ p[i*8 +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || (accept && is_reset)) cksum <= 8'h00;
    else if (mem_we)                    cksum <= cksum ^ xor_bytes(word);
  end
`else
  assign cksum = 8'h00;
`endif

endmodule
